spi_slave_word: RTL and testbench
=================================

Name: spi_slave_word

Overview:
- Next-generation SPI slave for moving AES key, plaintext and ciphertext blocks between the external master and the core.
- Runs entirely in the system clock domain: SCLK, CS and MOSI are oversampled through synchronisers instead of being used as clocks.
- Parametrised word width, SPI mode (CPOL/CPHA) and bit order.
- Supports back-to-back words within one CS frame, a valid/ready transmit handshake, a receive-valid strobe, and underrun/abort flags.

Parameters:
- DATA_W, 8: bits per word (8..128). AES blocks use 128.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- SYNC_STAGES, 2: synchroniser depth for SCLK, CS and MOSI (minimum 2).
- TX_IDLE, {DATA_W{1'b0}}: word transmitted when no transmit data is available.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI serial clock from the master (asynchronous).
- CS  input  1  chip select, active low (asynchronous).
- MOSI  input  1  master out, slave in.
- MISO  output  1  master in, slave out; 1'bz while synchronised CS is high.
- tx_data  input  DATA_W  next word to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; transfer occurs when tx_valid && tx_ready.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- busy  output  1  synchronised CS is low.
- tx_underrun  output  1  one-cycle strobe: a word load found the holding register empty.
- frame_abort  output  1  one-cycle strobe: CS deasserted mid-word.

Behaviour:
- Reset values:
  - Synchronisers: SCLK to CPOL, CS to 1, MOSI to 0.
  - rx_data = 0; rx_valid, tx_underrun, frame_abort, busy = 0.
  - tx_ready = 1; holding register empty; MISO = z.
- Frame and edge detection:
  - Edges are detected as synchronised value != previous synchronised value.
  - Leading edge = rising when CPOL=0, falling when CPOL=1. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
  - Requirement: f_clk >= 4 x f_SCLK. Edges are ignored while synchronised CS is high.
- States:
  - IDLE: CS high. On CS falling, load tx_shift, clear bit_cnt and first_edge=1, go ACTIVE.
  - ACTIVE: on each sample edge, shift MOSI into rx_shift and increment bit_cnt.
    - When bit_cnt reaches DATA_W-1, the next clk sets rx_data = assembled word, pulses rx_valid, and wraps bit_cnt to 0.
    - On each shift edge, advance tx_shift.
  - Exceptions to the shift rule:
    - CPHA=1: the first leading edge of each word only presents the first bit; it does not shift.
    - CPHA=0: the shift edge following the last sample loads the next word instead of shifting.
  - ACTIVE -> IDLE on CS rising.
    - If bit_cnt != 0: pulse frame_abort, discard the partial word, leave rx_data unchanged.
    - Holding register contents are retained.
- Word load (frame start or word boundary):
  - If the holding register is full: copy it into tx_shift and set tx_ready=1 the next cycle.
  - Else: load TX_IDLE and pulse tx_underrun.
  - A simultaneous tx_valid handshake in the load cycle is not used for the current load; it fills the holding register for the next word.
- MISO:
  - tx_shift[DATA_W-1] when MSB_FIRST, else tx_shift[0].
  - Registered; changes within 1 clk of the detected shift edge.
- Latency: rx_valid asserts SYNC_STAGES+2 clk after the final sample edge at the pin.
- rx has no backpressure: a new word overwrites rx_data. The consumer must take rx_data within one word time.
- Reset mid-frame: all state returns to reset values immediately. Until CS goes high then low again, SCLK activity is ignored (state stays IDLE).

Test Plan:
- Mode 0, DATA_W=16, MSB_FIRST=1: tx_data 0xA55A preloaded, master sends 0x3C96 -> rx_data=0x3C96, one rx_valid pulse, master receives 0xA55A, tx_ready low->high at frame start.
- Mode 3 (CPOL=1, CPHA=1), DATA_W=8: two back-to-back words in one CS frame, tx 0x81 then 0x7E supplied via handshake, master sends 0xC3, 0x24 -> rx_valid twice (0xC3, 0x24), master receives 0x81, 0x7E, no tx_underrun.
- Underrun: DATA_W=8, TX_IDLE=0xFF, no tx_valid ever -> tx_underrun pulses at CS falling, master receives 0xFF, rx still correct.
- Abort: CS raised after 5 of 8 bits -> frame_abort pulse, no rx_valid, rx_data unchanged; next full frame 0x5A received correctly.
- MSB_FIRST=0, DATA_W=8: master sends LSB-first bit stream of 0x01 -> rx_data=0x01; tx 0x80 emitted as 0,0,0,0,0,0,0,1.
- Reset asserted at bit 3 with CS held low -> outputs return to reset values, MISO=z; after CS high then low, a 0x99 transfer completes correctly.

Source files
------------

// File: rtl/spi_slave_word.sv
// Word-oriented SPI slave. SCLK, CS and MOSI are oversampled in the system clock domain.
// Supports back-to-back words per frame, a one-deep transmit holding register with a
// valid/ready handshake, and underrun/abort strobes.
module spi_slave_word #(
    parameter int unsigned       DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, settle_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge;

    state_e                 state_q;
    logic                   armed_q;
    logic                   first_edge_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      rx_shift_q, tx_shift_q, hold_q, rx_data_q;
    logic                   hold_full_q, done_q;
    logic                   rx_valid_q, tx_underrun_q, frame_abort_q;
    logic [DATA_W-1:0]      rx_shift_next, tx_shift_next;
    logic                   start, word_load;

    // Synchronise the SPI pins and remember the previous SCLK sample for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            settle_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // A frame may only start after CS has been seen high with a settled synchroniser, so a
    // CS line held low across reset does not look like a fresh falling edge.
    assign start = (state_q == StIdle) && armed_q && !cs_s;

    // Word boundary loads: frame start, or the first shift edge of a new word (CPHA=1 skips
    // the very first leading edge of the frame since the word was loaded at CS fall).
    assign word_load = start ||
                       ((state_q == StActive) && !cs_s && shift_edge && (bit_cnt_q == '0) &&
                        !(CPHA && first_edge_q));

    // Shift-register next values in the configured bit order.
    always_comb begin
        rx_shift_next = rx_shift_q;
        tx_shift_next = tx_shift_q;
        if (MSB_FIRST) begin
            rx_shift_next = {rx_shift_q[DATA_W-2:0], mosi_s};
            tx_shift_next = {tx_shift_q[DATA_W-2:0], 1'b0};
        end else begin
            rx_shift_next = {mosi_s, rx_shift_q[DATA_W-1:1]};
            tx_shift_next = {1'b0, tx_shift_q[DATA_W-1:1]};
        end
    end

    // Frame FSM, shift registers, holding register and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            armed_q       <= 1'b0;
            first_edge_q  <= 1'b0;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            done_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rx_valid_q    <= done_q;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            armed_q       <= armed_q | (settle_q[SYNC_STAGES-1] & cs_s);
            if (done_q) begin
                rx_data_q <= rx_shift_q;
            end

            if (word_load) begin
                if (hold_full_q) begin
                    tx_shift_q  <= hold_q;
                    hold_full_q <= 1'b0;
                end else begin
                    tx_shift_q    <= TX_IDLE;
                    tx_underrun_q <= 1'b1;
                end
            end
            // Only possible while empty, so it never collides with the load above.
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StActive;
                        bit_cnt_q    <= '0;
                        first_edge_q <= 1'b1;
                    end
                end
                StActive: begin
                    if (cs_s) begin
                        state_q <= StIdle;
                        if (bit_cnt_q != '0) begin
                            frame_abort_q <= 1'b1;
                        end
                        bit_cnt_q <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_shift_next;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (bit_cnt_q == '0) begin
                                first_edge_q <= 1'b0;
                            end else begin
                                tx_shift_q <= tx_shift_next;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign MISO        = cs_s ? 1'bz : (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = ~cs_s;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: three instances (mode 0 x16 MSB-first, mode 3 x8 with
// TX_IDLE=0xFF, mode 0 x8 LSB-first) driven by a bit-banged SPI master.
module tb_spi_slave_word;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  sclk = 3'b010;
    logic [2:0]  cs = 3'b111;
    logic        mosi = 1'b0;
    wire  [2:0]  miso;
    logic [15:0] tx_data0 = '0;
    logic [7:0]  tx_data1 = '0, tx_data2 = '0;
    logic [2:0]  tx_valid = '0;
    wire  [2:0]  tx_ready, rx_valid, busy, tx_underrun, frame_abort;
    wire  [15:0] rx_data0;
    wire  [7:0]  rx_data1, rx_data2;

    int errors = 0;
    int checks = 0;
    int rx_cnt[3];
    int und_cnt[3];
    int ab_cnt[3];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    always #5 clk = ~clk;

    spi_slave_word #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                     .SYNC_STAGES(2), .TX_IDLE(16'h0000)) u0 (
        .clk(clk), .reset(reset), .SCLK(sclk[0]), .CS(cs[0]), .MOSI(mosi), .MISO(miso[0]),
        .tx_data(tx_data0), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rx_data0), .rx_valid(rx_valid[0]), .busy(busy[0]),
        .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]));

    spi_slave_word #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1),
                     .SYNC_STAGES(2), .TX_IDLE(8'hFF)) u1 (
        .clk(clk), .reset(reset), .SCLK(sclk[1]), .CS(cs[1]), .MOSI(mosi), .MISO(miso[1]),
        .tx_data(tx_data1), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rx_data1), .rx_valid(rx_valid[1]), .busy(busy[1]),
        .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1]));

    spi_slave_word #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0),
                     .SYNC_STAGES(2), .TX_IDLE(8'h00)) u2 (
        .clk(clk), .reset(reset), .SCLK(sclk[2]), .CS(cs[2]), .MOSI(mosi), .MISO(miso[2]),
        .tx_data(tx_data2), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .rx_data(rx_data2), .rx_valid(rx_valid[2]), .busy(busy[2]),
        .tx_underrun(tx_underrun[2]), .frame_abort(frame_abort[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT strobes rx_valid, and counts strobes.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rx_valid[0]) begin
            rx_cnt[0]++;
            if (q0.size() == 0) chk("u0 unexpected rx_valid", 32'(rx_data0), 32'hDEAD_BEEF);
            else begin e = q0.pop_front(); chk("u0 rx_data", 32'(rx_data0), 32'(e)); end
        end
        if (rx_valid[1]) begin
            rx_cnt[1]++;
            if (q1.size() == 0) chk("u1 unexpected rx_valid", 32'(rx_data1), 32'hDEAD_BEEF);
            else begin e = q1.pop_front(); chk("u1 rx_data", 32'(rx_data1), 32'(e)); end
        end
        if (rx_valid[2]) begin
            rx_cnt[2]++;
            if (q2.size() == 0) chk("u2 unexpected rx_valid", 32'(rx_data2), 32'hDEAD_BEEF);
            else begin e = q2.pop_front(); chk("u2 rx_data", 32'(rx_data2), 32'(e)); end
        end
        for (int d = 0; d < 3; d++) begin
            if (tx_underrun[d]) und_cnt[d]++;
            if (frame_abort[d]) ab_cnt[d]++;
        end
    end

    task automatic push_tx(input int d, input logic [15:0] v);
        int n = 0;
        @(negedge clk);
        while (tx_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("tx_ready wait timeout", 32'(tx_ready[d]), 32'd1);
        end else begin
            case (d)
                0: tx_data0 = v;
                1: tx_data1 = v[7:0];
                default: tx_data2 = v[7:0];
            endcase
            tx_valid[d] = 1'b1;
            @(negedge clk);
            tx_valid[d] = 1'b0;
        end
    endtask

    task automatic frame_begin(input int d);
        cs[d] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic frame_end(input int d);
        #HALF;
        cs[d] = 1'b1;
        #(2 * HALF);
    endtask

    // Bit-bang one word; mi is the received word, seq holds MISO bits in arrival order.
    task automatic spi_word(input int d, input logic [15:0] mo, input int nbits,
                            output logic [15:0] mi, output logic [15:0] seq);
        logic cpol, cpha, msb;
        int   w, idx;
        cpol = (d == 1);
        cpha = (d == 1);
        msb  = (d != 2);
        w    = (d == 0) ? 16 : 8;
        mi   = '0;
        seq  = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi = mo[idx];
                #HALF;
                mi[idx] = miso[d];
                seq[i]  = miso[d];
                sclk[d] = ~cpol;
                #HALF;
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi    = mo[idx];
                #HALF;
                mi[idx] = miso[d];
                seq[i]  = miso[d];
                sclk[d] = cpol;
                #HALF;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mi, seq;
        int r, u, a;
        for (int d = 0; d < 3; d++) begin
            rx_cnt[d] = 0; und_cnt[d] = 0; ab_cnt[d] = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("reset tx_ready", 32'(tx_ready), 32'h7);
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset strobes", 32'({tx_underrun, frame_abort}), 32'h0);
        chk("reset rx_data", 32'({rx_data0, rx_data1, rx_data2}), 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Mode 0, 16-bit
        push_tx(0, 16'hA55A);
        chk("u0 tx_ready after preload", 32'(tx_ready[0]), 32'd0);
        q0.push_back(16'h3C96);
        frame_begin(0);
        chk("u0 tx_ready at frame start", 32'(tx_ready[0]), 32'd1);
        chk("u0 busy", 32'(busy[0]), 32'd1);
        spi_word(0, 16'h3C96, 16, mi, seq);
        chk("u0 master rx", 32'(mi), 32'hA55A);
        frame_end(0);
        chk("u0 rx_valid count", 32'(rx_cnt[0]), 32'd1);

        // Mode 3, two back-to-back words
        u = und_cnt[1];
        push_tx(1, 16'h0081);
        q1.push_back(16'h00C3);
        q1.push_back(16'h0024);
        frame_begin(1);
        push_tx(1, 16'h007E);
        spi_word(1, 16'h00C3, 8, mi, seq);
        chk("u1 master rx word0", 32'(mi), 32'h81);
        spi_word(1, 16'h0024, 8, mi, seq);
        chk("u1 master rx word1", 32'(mi), 32'h7E);
        frame_end(1);
        chk("u1 rx_valid count", 32'(rx_cnt[1]), 32'd2);
        chk("u1 no underrun", 32'(und_cnt[1]), 32'(u));

        // Underrun: holding register empty at CS fall
        q1.push_back(16'h0066);
        frame_begin(1);
        chk("u1 underrun at CS fall", 32'(und_cnt[1]), 32'(u + 1));
        spi_word(1, 16'h0066, 8, mi, seq);
        chk("u1 master rx idle word", 32'(mi), 32'hFF);
        frame_end(1);

        // Abort after 5 of 8 bits
        r = rx_cnt[1];
        a = ab_cnt[1];
        frame_begin(1);
        spi_word(1, 16'h00A5, 5, mi, seq);
        frame_end(1);
        chk("u1 frame_abort", 32'(ab_cnt[1]), 32'(a + 1));
        chk("u1 no rx on abort", 32'(rx_cnt[1]), 32'(r));
        chk("u1 rx_data kept", 32'(rx_data1), 32'h66);
        q1.push_back(16'h005A);
        frame_begin(1);
        spi_word(1, 16'h005A, 8, mi, seq);
        frame_end(1);
        chk("u1 rx after abort", 32'(rx_cnt[1]), 32'(r + 1));

        // LSB first
        push_tx(2, 16'h0080);
        q2.push_back(16'h0001);
        frame_begin(2);
        spi_word(2, 16'h0001, 8, mi, seq);
        chk("u2 MISO bit sequence", 32'(seq), 32'h80);
        frame_end(2);
        chk("u2 rx_valid count", 32'(rx_cnt[2]), 32'd1);

        // Reset mid-word with CS held low
        frame_begin(1);
        spi_word(1, 16'h00F0, 3, mi, seq);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid reset tx_ready", 32'(tx_ready), 32'h7);
        chk("mid reset busy", 32'(busy), 32'h0);
        chk("mid reset rx_data", 32'({rx_data0, rx_data1, rx_data2}), 32'h0);
        chk("mid reset strobes", 32'({rx_valid, tx_underrun, frame_abort}), 32'h0);
        reset = 1'b1;
        r = rx_cnt[1];
        u = und_cnt[1];
        a = ab_cnt[1];
        repeat (4) @(negedge clk);
        spi_word(1, 16'h00FF, 8, mi, seq);
        frame_end(1);
        chk("ignored SCLK no rx", 32'(rx_cnt[1]), 32'(r));
        chk("ignored SCLK no load", 32'(und_cnt[1]), 32'(u));
        chk("ignored SCLK no abort", 32'(ab_cnt[1]), 32'(a));
        push_tx(1, 16'h0042);
        q1.push_back(16'h0099);
        frame_begin(1);
        spi_word(1, 16'h0099, 8, mi, seq);
        chk("u1 master rx after reset", 32'(mi), 32'h42);
        frame_end(1);
        chk("u1 rx after reset", 32'(rx_cnt[1]), 32'(r + 1));

        chk("u0 scoreboard drained", 32'(q0.size()), 32'd0);
        chk("u1 scoreboard drained", 32'(q1.size()), 32'd0);
        chk("u2 scoreboard drained", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
